// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and select encoding for the EXE-stage forwarding/hazard controller.
package fwd_hazard_ctrl_pkg;

  localparam int ADDR_W       = 5;
  localparam int FORW_SEL_LEN = 2;

  // EXE datapath decodes these values; 2'd3 is never produced.
  localparam logic [FORW_SEL_LEN-1:0] FORW_SEL_ID  = 2'd0;
  localparam logic [FORW_SEL_LEN-1:0] FORW_SEL_MEM = 2'd1;
  localparam logic [FORW_SEL_LEN-1:0] FORW_SEL_WB  = 2'd2;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t dest;
    logic      wb_en;
    logic      mem_r_en;
  } stage_ctl_t;

  localparam stage_ctl_t STAGE_BUBBLE = '0;

  // Register $0 is hardwired, so a match on it is never a real dependency.
  function automatic logic addr_hit(input reg_addr_t src, input stage_ctl_t ctl);
    return ctl.wb_en && (ctl.dest == src) && (src != '0);
  endfunction

endpackage

// File: rtl/fwd_sel_cmp.sv
// Picks the forwarding source for one EXE operand; the younger MEM producer wins over WB.
module fwd_sel_cmp
  import fwd_hazard_ctrl_pkg::*;
(
  input  reg_addr_t                src,
  input  logic                     en,
  input  stage_ctl_t               mem_ctl,
  input  stage_ctl_t               wb_ctl,
  input  logic                     fwd_en,
  output logic [FORW_SEL_LEN-1:0]  sel
);

  logic unused_ctl;
  assign unused_ctl = mem_ctl.mem_r_en ^ wb_ctl.mem_r_en;

  always_comb begin
    sel = FORW_SEL_ID;
    if (fwd_en && en) begin
      if (addr_hit(src, mem_ctl)) begin
        sel = FORW_SEL_MEM;
      end else if (addr_hit(src, wb_ctl)) begin
        sel = FORW_SEL_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EXE forwarding selects and ID load-use stall, driven by a private shadow of the
// EXE/MEM/WB register-address pipeline so only ID decode fields are needed as inputs.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_LEN = ADDR_W,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fwd_en,
  input  logic                     flush,
  input  logic [REG_ADDR_LEN-1:0]  src1_ID,
  input  logic [REG_ADDR_LEN-1:0]  src2_ID,
  input  logic [REG_ADDR_LEN-1:0]  dest_ID,
  input  logic                     WB_EN_ID,
  input  logic                     MEM_R_EN_ID,
  input  logic                     is_st_ID,
  input  logic                     two_src_ID,
  output logic [FORW_SEL_LEN-1:0]  val1_sel,
  output logic [FORW_SEL_LEN-1:0]  val2_sel,
  output logic [FORW_SEL_LEN-1:0]  ST_val_sel,
  output logic                     hazard_stall,
  output logic [CNT_W-1:0]         stall_cnt
);

  stage_ctl_t exe_ctl, mem_ctl, wb_ctl;
  reg_addr_t  src1_exe, src2_exe;
  logic       is_st_exe, two_src_exe;

  reg_addr_t  src1_id, src2_id, dest_id;
  logic       src2_used;
  logic       hit1_exe, hit2_exe, hit1_mem, hit2_mem;
  logic       load_use, raw_no_fwd, stall_raw;

  assign src1_id = src1_ID;
  assign src2_id = src2_ID;
  assign dest_id = dest_ID;

  // Stores read rt as data even when the ALU uses an immediate.
  assign src2_used = two_src_ID | is_st_ID;

  always_comb begin
    hit1_exe   = addr_hit(src1_id, exe_ctl);
    hit2_exe   = src2_used && addr_hit(src2_id, exe_ctl);
    hit1_mem   = addr_hit(src1_id, mem_ctl);
    hit2_mem   = src2_used && addr_hit(src2_id, mem_ctl);
    load_use   = exe_ctl.mem_r_en && (hit1_exe || hit2_exe);
    raw_no_fwd = hit1_exe || hit2_exe || hit1_mem || hit2_mem;
    stall_raw  = fwd_en ? load_use : raw_no_fwd;
    hazard_stall = stall_raw && !flush;
  end

  // WB never stalls: the register file writes on the falling edge, ahead of the ID read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_ctl     <= STAGE_BUBBLE;
      mem_ctl     <= STAGE_BUBBLE;
      wb_ctl      <= STAGE_BUBBLE;
      src1_exe    <= '0;
      src2_exe    <= '0;
      is_st_exe   <= 1'b0;
      two_src_exe <= 1'b0;
    end else begin
      if (hazard_stall || flush) begin
        exe_ctl     <= STAGE_BUBBLE;
        src1_exe    <= '0;
        src2_exe    <= '0;
        is_st_exe   <= 1'b0;
        two_src_exe <= 1'b0;
      end else begin
        exe_ctl     <= '{dest: dest_id, wb_en: WB_EN_ID, mem_r_en: MEM_R_EN_ID};
        src1_exe    <= src1_id;
        src2_exe    <= src2_id;
        is_st_exe   <= is_st_ID;
        two_src_exe <= two_src_ID;
      end
      mem_ctl <= exe_ctl;
      wb_ctl  <= '{dest: mem_ctl.dest, wb_en: mem_ctl.wb_en, mem_r_en: 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (hazard_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  fwd_sel_cmp u_val1_cmp (
    .src     (src1_exe),
    .en      (1'b1),
    .mem_ctl (mem_ctl),
    .wb_ctl  (wb_ctl),
    .fwd_en  (fwd_en),
    .sel     (val1_sel)
  );

  fwd_sel_cmp u_val2_cmp (
    .src     (src2_exe),
    .en      (two_src_exe),
    .mem_ctl (mem_ctl),
    .wb_ctl  (wb_ctl),
    .fwd_en  (fwd_en),
    .sel     (val2_sel)
  );

  fwd_sel_cmp u_st_cmp (
    .src     (src2_exe),
    .en      (is_st_exe),
    .mem_ctl (mem_ctl),
    .wb_ctl  (wb_ctl),
    .fwd_en  (fwd_en),
    .sel     (ST_val_sel)
  );

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl; counter built narrow so saturation is reachable.
module tb_fwd_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             fwd_en, flush;
  logic [4:0]       src1_ID, src2_ID, dest_ID;
  logic             WB_EN_ID, MEM_R_EN_ID, is_st_ID, two_src_ID;
  logic [1:0]       val1_sel, val2_sel, ST_val_sel;
  logic             hazard_stall;
  logic [CNT_W-1:0] stall_cnt;

  int checkCount = 0;
  int errorCount = 0;
  int expCnt     = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_ADDR_LEN(5), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .fwd_en       (fwd_en),
    .flush        (flush),
    .src1_ID      (src1_ID),
    .src2_ID      (src2_ID),
    .dest_ID      (dest_ID),
    .WB_EN_ID     (WB_EN_ID),
    .MEM_R_EN_ID  (MEM_R_EN_ID),
    .is_st_ID     (is_st_ID),
    .two_src_ID   (two_src_ID),
    .val1_sel     (val1_sel),
    .val2_sel     (val2_sel),
    .ST_val_sel   (ST_val_sel),
    .hazard_stall (hazard_stall),
    .stall_cnt    (stall_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Drives one ID-stage instruction and lets the combinational stall settle.
  task automatic applyStimulus(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                               input logic wb, input logic mr, input logic st, input logic two);
    src1_ID = s1; src2_ID = s2; dest_ID = d;
    WB_EN_ID = wb; MEM_R_EN_ID = mr; is_st_ID = st; two_src_ID = two;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b0; fwd_en = 1'b1; flush = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_val1", val1_sel, 0);
    checkOutput("reset_val2", val2_sel, 0);
    checkOutput("reset_st", ST_val_sel, 0);
    checkOutput("reset_stall", hazard_stall, 0);
    checkOutput("reset_cnt", stall_cnt, 0);
    #2 rst = 1'b1;
    tick();

    // Forward from MEM
    applyStimulus(0, 0, 3, 1, 0, 0, 0); tick();
    applyStimulus(3, 0, 8, 1, 0, 0, 0);
    checkOutput("t1_no_stall", hazard_stall, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_val1_mem", val1_sel, 1);
    checkOutput("t1_val2_id", val2_sel, 0);
    drain();

    // MEM beats WB, then WB-only forwarding
    applyStimulus(0, 0, 5, 1, 0, 0, 0); tick();
    applyStimulus(0, 0, 5, 1, 0, 0, 0); tick();
    applyStimulus(5, 5, 9, 1, 0, 0, 1); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_val1_prio", val1_sel, 1);
    checkOutput("t2_val2_prio", val2_sel, 1);
    checkOutput("t2_st_nostore", ST_val_sel, 0);
    drain();
    applyStimulus(0, 0, 5, 1, 0, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(5, 5, 9, 1, 0, 0, 1); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_val1_wb", val1_sel, 2);
    checkOutput("t2_val2_wb", val2_sel, 2);
    drain();

    // Load-use into a store's data operand
    applyStimulus(0, 0, 4, 1, 1, 0, 0); tick();
    applyStimulus(2, 4, 0, 0, 0, 1, 0);
    checkOutput("t3_stall", hazard_stall, 1);
    tick(); expCnt++;
    checkOutput("t3_cnt", stall_cnt, expCnt);
    checkOutput("t3_stall_once", hazard_stall, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t3_st_wb", ST_val_sel, 2);
    checkOutput("t3_val1", val1_sel, 0);
    checkOutput("t3_val2_imm", val2_sel, 0);
    drain();

    // Register $0 and immediate operand
    applyStimulus(0, 0, 0, 1, 1, 0, 0); tick();
    applyStimulus(0, 0, 7, 1, 0, 1, 1);
    checkOutput("t4_r0_stall", hazard_stall, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_r0_val1", val1_sel, 0);
    checkOutput("t4_r0_val2", val2_sel, 0);
    checkOutput("t4_r0_st", ST_val_sel, 0);
    drain();
    applyStimulus(0, 0, 6, 1, 1, 0, 0); tick();
    applyStimulus(1, 6, 2, 1, 0, 0, 0);
    checkOutput("t4_imm_nostall", hazard_stall, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_imm_val2", val2_sel, 0);
    checkOutput("t4_imm_val1", val1_sel, 0);
    drain();

    // Forwarding disabled: stall until producer reaches WB
    fwd_en = 1'b0;
    applyStimulus(0, 0, 7, 1, 0, 0, 0); tick();
    applyStimulus(7, 0, 1, 1, 0, 0, 0);
    checkOutput("t5_stall_exe", hazard_stall, 1);
    tick(); expCnt++;
    checkOutput("t5_stall_mem", hazard_stall, 1);
    tick(); expCnt++;
    checkOutput("t5_release", hazard_stall, 0);
    checkOutput("t5_cnt", stall_cnt, expCnt);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_val1_off", val1_sel, 0);
    drain();

    // Flush during a load-use stall
    fwd_en = 1'b1;
    applyStimulus(0, 0, 4, 1, 1, 0, 0); tick();
    applyStimulus(4, 0, 1, 1, 0, 0, 0);
    flush = 1'b1; #1;
    checkOutput("t5_flush_stall", hazard_stall, 0);
    tick();
    flush = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_flush_cnt", stall_cnt, expCnt);
    tick();
    checkOutput("t5_flush_val1", val1_sel, 0);
    drain();

    // Asynchronous reset in the middle of a stall
    applyStimulus(0, 0, 4, 1, 1, 0, 0); tick();
    applyStimulus(4, 0, 1, 1, 0, 0, 0);
    checkOutput("t6_pre_stall", hazard_stall, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("t6_async_stall", hazard_stall, 0);
    checkOutput("t6_async_cnt", stall_cnt, 0);
    #1 rst = 1'b1;
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_no_resume", hazard_stall, 0);
    drain();

    // Saturation: self-dependent chain with forwarding off stalls 2 of every 3 cycles
    fwd_en = 1'b0;
    applyStimulus(1, 0, 1, 1, 0, 0, 0);
    repeat (30) tick();
    checkOutput("t6_saturate", stall_cnt, 15);
    repeat (3) tick();
    checkOutput("t6_hold", stall_cnt, 15);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
